combined_spi_buffer_avalon_debugger: RTL and testbench

//  Passive SPI bus logger. Captures each completed MOSI byte and MISO byte, paired as one entry,

---
 rtl/spi_dbg_pkg.sv | 39 +++
 rtl/spi_dbg_edge_sync.sv | 24 ++
 rtl/combined_spi_buffer_avalon_debugger.sv | 108 ++++++++++
 tb/tb_combined_spi_buffer_avalon_debugger.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dbg_pkg.sv
// Shared definitions for the passive SPI bus logger: log geometry, entry layout and entry builder.
package spi_dbg_pkg;

    localparam int LOG_DEPTH_MAX  = 63;
    localparam int STATUS_ADDR    = 0;

    localparam int ENTRY_TS_LSB   = 32;
    localparam int ENTRY_MISO_LSB = 8;
    localparam int ENTRY_MOSI_LSB = 0;
    localparam int MISO_VALID_BIT = 17;
    localparam int MOSI_VALID_BIT = 16;
    localparam int STATUS_OVF_BIT = 8;

    typedef struct packed {
        logic [31:0] timestamp;
        logic [13:0] reserved;
        logic        miso_valid;
        logic        mosi_valid;
        logic [7:0]  miso_byte;
        logic [7:0]  mosi_byte;
    } entry_t;

    // A byte whose valid bit is clear is logged as zero rather than whatever the deserialiser holds.
    function automatic entry_t make_entry(input logic [31:0] ts,
                                          input logic       mosi_v,
                                          input logic [7:0] mosi_b,
                                          input logic       miso_v,
                                          input logic [7:0] miso_b);
        entry_t e;
        e.timestamp  = ts;
        e.reserved   = '0;
        e.miso_valid = miso_v;
        e.mosi_valid = mosi_v;
        e.miso_byte  = miso_v ? miso_b : 8'h00;
        e.mosi_byte  = mosi_v ? mosi_b : 8'h00;
        return e;
    endfunction

endpackage

// File: rtl/spi_dbg_edge_sync.sv
// Brings an SPI-domain "byte changed" flag into the system clock domain and emits a one-cycle pulse per rising edge.
module spi_dbg_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
        end
    end

    assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/combined_spi_buffer_avalon_debugger.sv
// Passive SPI logger: pairs captured MOSI/MISO bytes into a non-wrapping log readable over Avalon-MM.
// Optional timestamp counter enabled by defining DBG_TIMESTAMP_EN.
module combined_spi_buffer_avalon_debugger
    import spi_dbg_pkg::*;
#(
    parameter int LOG_DEPTH = 63,
    parameter int TS_WIDTH  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  io_MOSI_Buffer,
    input  logic        io_MOSI_BufferChanged,
    input  logic [7:0]  io_MISO_Buffer,
    input  logic        io_MISO_BufferChanged,
    input  logic [5:0]  io_Avalon_address,
    input  logic        io_Avalon_read,
    output logic [63:0] io_Avalon_readdata
);

    localparam logic [5:0] DEPTH = 6'(LOG_DEPTH);

    logic        mosi_ev;
    logic        miso_ev;
    logic        capture;
    logic [5:0]  count;
    logic        overflow;
    logic [31:0] ts_ext;
    logic [5:0]  rd_idx;
    logic [63:0] status_word;
    logic [63:0] log_mem [0:LOG_DEPTH-1];

    spi_dbg_edge_sync u_mosi_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (io_MOSI_BufferChanged),
        .pulse    (mosi_ev)
    );

    spi_dbg_edge_sync u_miso_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (io_MISO_BufferChanged),
        .pulse    (miso_ev)
    );

`ifdef DBG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
        end
    end

    assign ts_ext = 32'(ts);
`else
    assign ts_ext = 32'h0;
`endif

    assign capture = (mosi_ev | miso_ev) && (count < DEPTH);

    // Once full the log freezes; later events only raise the sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= 6'd0;
            overflow <= 1'b0;
        end else if (mosi_ev | miso_ev) begin
            if (count < DEPTH) begin
                count <= count + 6'd1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (capture) begin
            log_mem[count] <= make_entry(ts_ext, mosi_ev, io_MOSI_Buffer, miso_ev, io_MISO_Buffer);
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[ENTRY_TS_LSB +: 32]      = ts_ext;
        status_word[STATUS_OVF_BIT]          = overflow;
        status_word[5:0]                     = count;
    end

    assign rd_idx = io_Avalon_address - 6'd1;

    // Entry at address a lives at RAM index a-1; anything past the fill level reads as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_Avalon_readdata <= 64'h0;
        end else if (io_Avalon_read) begin
            if (io_Avalon_address == 6'(STATUS_ADDR)) begin
                io_Avalon_readdata <= status_word;
            end else if (io_Avalon_address <= count) begin
                io_Avalon_readdata <= log_mem[rd_idx];
            end else begin
                io_Avalon_readdata <= 64'h0;
            end
        end
    end

endmodule

// File: tb/tb_combined_spi_buffer_avalon_debugger.sv
// Self-checking bench for the SPI logger: table vectors, hand sequences and a randomized queue-based model.
module tb_combined_spi_buffer_avalon_debugger;

    localparam int LOG_DEPTH = 63;
`ifdef DBG_TIMESTAMP_EN
    localparam logic [63:0] ENTRY_MASK = 64'h0000_0000_FFFF_FFFF;
`else
    localparam logic [63:0] ENTRY_MASK = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  io_MOSI_Buffer;
    logic        io_MOSI_BufferChanged;
    logic [7:0]  io_MISO_Buffer;
    logic        io_MISO_BufferChanged;
    logic [5:0]  io_Avalon_address;
    logic        io_Avalon_read;
    logic [63:0] io_Avalon_readdata;

    combined_spi_buffer_avalon_debugger dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_MOSI_Buffer        (io_MOSI_Buffer),
        .io_MOSI_BufferChanged (io_MOSI_BufferChanged),
        .io_MISO_Buffer        (io_MISO_Buffer),
        .io_MISO_BufferChanged (io_MISO_BufferChanged),
        .io_Avalon_address     (io_Avalon_address),
        .io_Avalon_read        (io_Avalon_read),
        .io_Avalon_readdata    (io_Avalon_readdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       mv;
        logic [7:0] mb;
        logic       sv;
        logic [7:0] sb;
        logic [17:0] exp;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [17:0] exp_q[$];
    logic        exp_ovf = 1'b0;

    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic read_word(input logic [5:0] addr, output logic [63:0] data);
        io_Avalon_address = addr;
        io_Avalon_read    = 1'b1;
        tick();
        io_Avalon_read    = 1'b0;
        tick();
        data = io_Avalon_readdata;
    endtask

    task automatic model_capture(input logic mv, input logic [7:0] mb, input logic sv, input logic [7:0] sb);
        if (exp_q.size() < LOG_DEPTH)
            exp_q.push_back({sv, mv, (sv ? sb : 8'h00), (mv ? mb : 8'h00)});
        else
            exp_ovf = 1'b1;
    endtask

    task automatic applyStimulus(input logic mv, input logic [7:0] mb, input logic sv, input logic [7:0] sb);
        io_MOSI_Buffer        = mb;
        io_MISO_Buffer        = sb;
        io_MOSI_BufferChanged = mv;
        io_MISO_BufferChanged = sv;
        repeat (4) tick();
        io_MOSI_BufferChanged = 1'b0;
        io_MISO_BufferChanged = 1'b0;
        repeat (4) tick();
        model_capture(mv, mb, sv, sb);
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        io_MOSI_BufferChanged = 1'b0;
        io_MISO_BufferChanged = 1'b0;
        io_Avalon_read        = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        tick();
    endtask

    task automatic check_log(input string tag);
        logic [63:0] d;
        int n;
        n = exp_q.size();
        read_word(6'd0, d);
        checkOutput({tag, " status"}, d & ENTRY_MASK,
                    {32'h0, 23'h0, exp_ovf, 2'b00, 6'(n)} & ENTRY_MASK);
        for (int a = 1; a <= LOG_DEPTH && a <= n + 2; a++) begin
            read_word(6'(a), d);
            if (a <= n)
                checkOutput($sformatf("%s addr%0d", tag, a), d & ENTRY_MASK, {46'h0, exp_q[a-1]} & ENTRY_MASK);
            else
                checkOutput($sformatf("%s addr%0d empty", tag, a), d, 64'h0);
        end
    endtask

    initial begin
        vec_t        tbl[4];
        logic [63:0] d, d1, d2;
        int          t_a, t_b, k, kind;
        logic [7:0]  rb, rs;

        tbl[0] = '{1'b1, 8'h7A, 1'b1, 8'h14, 18'h3147A};
        tbl[1] = '{1'b1, 8'h80, 1'b1, 8'hC8, 18'h3C880};
        tbl[2] = '{1'b0, 8'h55, 1'b1, 8'h10, 18'h21000};
        tbl[3] = '{1'b1, 8'h3C, 1'b0, 8'hA5, 18'h1003C};

        io_MOSI_Buffer    = 8'h00;
        io_MISO_Buffer    = 8'h00;
        io_Avalon_address = 6'd0;
        do_reset();
        checkOutput("reset readdata", io_Avalon_readdata, 64'h0);

        // Reset landing in the middle of a capture wipes count, overflow and readdata.
        applyStimulus(1'b1, 8'hAA, 1'b1, 8'h55);
        read_word(6'd1, d);
        checkOutput("pre-reset entry", d & ENTRY_MASK, 64'h3_55AA & ENTRY_MASK);
        io_MOSI_BufferChanged = 1'b1;
        io_MISO_BufferChanged = 1'b1;
        tick();
        tick();
        #2 reset = 1'b1;
        io_MOSI_BufferChanged = 1'b0;
        io_MISO_BufferChanged = 1'b0;
        #1 checkOutput("async reset readdata", io_Avalon_readdata, 64'h0);
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        tick();
        check_log("after reset");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(tbl[i].mv, tbl[i].mb, tbl[i].sv, tbl[i].sb);
            read_word(6'(i + 1), d);
            checkOutput($sformatf("table vec%0d", i), d & ENTRY_MASK, {46'h0, tbl[i].exp} & ENTRY_MASK);
        end
        check_log("table");
        read_word(6'd5, d);
        checkOutput("addr beyond count", d, 64'h0);

        read_word(6'd1, d);
        io_Avalon_address = 6'd2;
        repeat (3) tick();
        checkOutput("readdata hold", io_Avalon_readdata & ENTRY_MASK, {46'h0, tbl[0].exp} & ENTRY_MASK);

        // Read strobe coincides with the write edge of the next entry: old (empty) content is returned.
        io_MOSI_Buffer        = 8'h11;
        io_MISO_Buffer        = 8'h22;
        io_MOSI_BufferChanged = 1'b1;
        io_MISO_BufferChanged = 1'b1;
        tick();
        tick();
        io_Avalon_address = 6'd5;
        io_Avalon_read    = 1'b1;
        tick();
        io_Avalon_read    = 1'b0;
        tick();
        checkOutput("same-cycle read", io_Avalon_readdata, 64'h0);
        io_MOSI_BufferChanged = 1'b0;
        io_MISO_BufferChanged = 1'b0;
        repeat (4) tick();
        model_capture(1'b1, 8'h11, 1'b1, 8'h22);
        check_log("after same-cycle");

        do_reset();
        k = $urandom_range(3, 20);
        t_a = cyc;
        applyStimulus(1'b1, 8'h01, 1'b0, 8'h00);
        repeat (k) tick();
        t_b = cyc;
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h02);
        read_word(6'd1, d1);
        read_word(6'd2, d2);
`ifdef DBG_TIMESTAMP_EN
        checkOutput("timestamp delta", 64'(d2[63:32] - d1[63:32]), 64'(t_b - t_a));
`else
        checkOutput("timestamp1 absent", {32'h0, d1[63:32]}, 64'h0);
        checkOutput("timestamp2 absent", {32'h0, d2[63:32]}, 64'h0);
        read_word(6'd0, d);
        checkOutput("status timestamp absent", {32'h0, d[63:32]}, 64'h0);
`endif

        do_reset();
        for (int i = 0; i < 20; i++) begin
            kind = $urandom_range(0, 2);
            rb   = 8'($urandom);
            rs   = 8'($urandom);
            applyStimulus(kind != 2, rb, kind != 1, rs);
        end
        check_log("random");
        for (int i = 0; i < 50; i++) begin
            rb = 8'($urandom);
            rs = 8'($urandom);
            applyStimulus(1'b1, rb, 1'b1, rs);
        end
        check_log("overflow");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
